// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory read bus between fetch unit and imem
interface instruction_fetch_unit_if;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  modport master (output imem_address, imem_read, input imem_readdata, imem_busywait);
  modport slave (input imem_address, imem_read, output imem_readdata, imem_busywait);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, imem fetch with busywait, branch redirect and IF/ID register
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             branch_taken,
  input  logic [31:0]                      branch_target,
  input  logic                             hazard_stall,
  input  logic                             data_mem_busywait,
  instruction_fetch_unit_if.master         imem,
  output logic [31:0]                      instruction,
  output logic [31:0]                      pc_out,
  output logic                             if_id_valid
);
  typedef enum logic {FETCH, REDIRECT_PENDING} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, pend, pend_n, instr_n, pc_out_n, target;
  logic valid_n, fetch_done, bubble;
  assign imem.imem_address = pc;
  assign imem.imem_read = !reset;
  assign fetch_done = imem.imem_read && !imem.imem_busywait;
  assign target = branch_target & ~32'h3;
  always_comb begin
    state_n = state;
    pc_n = pc;
    pend_n = pend;
    bubble = 1'b0;
    instr_n = instruction;
    pc_out_n = pc_out;
    valid_n = if_id_valid;
    if (!data_mem_busywait) begin
      if (state == REDIRECT_PENDING) begin
        bubble = 1'b1;
        pc_n = fetch_done ? pend : pc;
        state_n = fetch_done ? FETCH : REDIRECT_PENDING;
      end else if (branch_taken) begin
        bubble = 1'b1;
        pc_n = imem.imem_busywait ? pc : target;
        pend_n = imem.imem_busywait ? target : pend;
        state_n = imem.imem_busywait ? REDIRECT_PENDING : FETCH;
      end else if (!hazard_stall) begin
        bubble = !fetch_done;
        pc_n = fetch_done ? pc + 32'd4 : pc;
        instr_n = imem.imem_readdata;
        pc_out_n = pc;
        valid_n = 1'b1;
      end
    end
    if (bubble) begin
      instr_n = BUBBLE_INSTR;
      pc_out_n = 32'h0;
      valid_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      pend <= 32'h0;
      instruction <= BUBBLE_INSTR;
      pc_out <= 32'h0;
      if_id_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      pend <= pend_n;
      instruction <= instr_n;
      pc_out <= pc_out_n;
      if_id_valid <= valid_n;
    end
  end
endmodule
